// File: rtl/dp_alu_flags.sv
// Execute-stage ALU for data-processing instructions. Evaluates the condition
// field against the held NZCV, computes the result, updates NZCV and issues a
// registered write-back request for Rd.
module dp_alu_flags (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        in_valid,
  input  logic [3:0]  IR_cond,
  input  logic [3:0]  IR_cmd,
  input  logic        IR_S,
  input  logic [3:0]  IR_Rd,
  input  logic [31:0] RF_Rn,
  input  logic [31:0] src2,
  input  logic        was_shifted,
  input  logic        carryBit,
  input  logic        flags_ld,
  input  logic [3:0]  flags_in,
  output logic [31:0] result,
  output logic [3:0]  wb_Rd,
  output logic        wb_en,
  output logic        result_valid,
  output logic        cond_pass,
  output logic [3:0]  flags
);

  localparam logic [3:0] OpAnd = 4'h0;
  localparam logic [3:0] OpEor = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpRsb = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpAdc = 4'h5;
  localparam logic [3:0] OpSbc = 4'h6;
  localparam logic [3:0] OpRsc = 4'h7;
  localparam logic [3:0] OpTst = 4'h8;
  localparam logic [3:0] OpTeq = 4'h9;
  localparam logic [3:0] OpCmp = 4'hA;
  localparam logic [3:0] OpCmn = 4'hB;
  localparam logic [3:0] OpOrr = 4'hC;
  localparam logic [3:0] OpMov = 4'hD;
  localparam logic [3:0] OpBic = 4'hE;
  localparam logic [3:0] OpMvn = 4'hF;

  logic        fn, fz, fc, fv;
  logic        cond_ok;
  logic        is_arith;
  logic        is_cmp;
  logic [31:0] op_a, op_b;
  logic        cin;
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] alu_res;
  logic [3:0]  nzcv_next;

  assign {fn, fz, fc, fv} = flags;

  // Condition check against the flags held before this instruction.
  always_comb begin
    cond_ok = 1'b0;
    case (IR_cond)
      4'h0: cond_ok = fz;
      4'h1: cond_ok = !fz;
      4'h2: cond_ok = fc;
      4'h3: cond_ok = !fc;
      4'h4: cond_ok = fn;
      4'h5: cond_ok = !fn;
      4'h6: cond_ok = fv;
      4'h7: cond_ok = !fv;
      4'h8: cond_ok = fc && !fz;
      4'h9: cond_ok = !fc || fz;
      4'hA: cond_ok = (fn == fv);
      4'hB: cond_ok = (fn != fv);
      4'hC: cond_ok = !fz && (fn == fv);
      4'hD: cond_ok = fz || (fn != fv);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Adder operand selection: subtracts become a + ~b + 1 (or + C), so bit 32
  // is directly the not-borrow carry.
  always_comb begin
    op_a     = RF_Rn;
    op_b     = src2;
    cin      = 1'b0;
    is_arith = 1'b1;
    case (IR_cmd)
      OpSub, OpCmp: begin op_b = ~src2; cin = 1'b1; end
      OpRsb:        begin op_a = src2; op_b = ~RF_Rn; cin = 1'b1; end
      OpAdd, OpCmn: cin = 1'b0;
      OpAdc:        cin = fc;
      OpSbc:        begin op_b = ~src2; cin = fc; end
      OpRsc:        begin op_a = src2; op_b = ~RF_Rn; cin = fc; end
      default:      is_arith = 1'b0;
    endcase
  end

  assign sum    = {1'b0, op_a} + {1'b0, op_b} + {32'd0, cin};
  assign ovf    = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
  assign is_cmp = (IR_cmd[3:2] == 2'b10);

  // Result mux and next NZCV.
  always_comb begin
    alu_res = sum[31:0];
    case (IR_cmd)
      OpAnd, OpTst: alu_res = RF_Rn & src2;
      OpEor, OpTeq: alu_res = RF_Rn ^ src2;
      OpOrr:        alu_res = RF_Rn | src2;
      OpMov:        alu_res = src2;
      OpBic:        alu_res = RF_Rn & ~src2;
      OpMvn:        alu_res = ~src2;
      default:      alu_res = sum[31:0];
    endcase
    nzcv_next[3] = alu_res[31];
    nzcv_next[2] = (alu_res == 32'd0);
    nzcv_next[1] = is_arith ? sum[32] : (was_shifted ? carryBit : fc);
    nzcv_next[0] = is_arith ? ovf : fv;
  end

  // Output and flag registers; an MSR-style load beats an instruction update.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      result       <= 32'd0;
      wb_Rd        <= 4'd0;
      wb_en        <= 1'b0;
      result_valid <= 1'b0;
      cond_pass    <= 1'b0;
      flags        <= 4'b0000;
    end else begin
      if (in_valid) begin
        result       <= alu_res;
        wb_Rd        <= IR_Rd;
        cond_pass    <= cond_ok;
        wb_en        <= cond_ok && !is_cmp;
        result_valid <= 1'b1;
      end else begin
        wb_en        <= 1'b0;
        result_valid <= 1'b0;
      end
      if (flags_ld) begin
        flags <= flags_in;
      end else if (in_valid && cond_ok && (IR_S || is_cmp)) begin
        flags <= nzcv_next;
      end
    end
  end

endmodule

// File: tb/tb_dp_alu_flags.sv
// Scoreboard bench for dp_alu_flags: a reference model computes expected
// outputs per cycle, pushes them to a queue, and they are popped and compared
// after the clock edge.
module tb_dp_alu_flags;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N, in_valid, IR_S, was_shifted, carryBit, flags_ld;
  logic [3:0]  IR_cond, IR_cmd, IR_Rd, flags_in;
  logic [31:0] RF_Rn, src2;
  logic [31:0] result;
  logic [3:0]  wb_Rd, flags;
  logic        wb_en, result_valid, cond_pass;

  dp_alu_flags dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .in_valid     (in_valid),
    .IR_cond      (IR_cond),
    .IR_cmd       (IR_cmd),
    .IR_S         (IR_S),
    .IR_Rd        (IR_Rd),
    .RF_Rn        (RF_Rn),
    .src2         (src2),
    .was_shifted  (was_shifted),
    .carryBit     (carryBit),
    .flags_ld     (flags_ld),
    .flags_in     (flags_in),
    .result       (result),
    .wb_Rd        (wb_Rd),
    .wb_en        (wb_en),
    .result_valid (result_valid),
    .cond_pass    (cond_pass),
    .flags        (flags)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic        rv;
    logic        cp;
    logic [3:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return c;
      4'h3: return ~c;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return c & ~z;
      4'h9: return ~c | z;
      4'hA: return n ~^ v;
      4'hB: return n ^ v;
      4'hC: return ~z & (n ~^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic modelled with wide unsigned/signed integers, not an adder.
  task automatic alu_model(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] s2,
                           input logic ws, input logic cb, input logic [3:0] f,
                           output logic [31:0] r, output logic [3:0] nf);
    longint unsigned ua, ub, full;
    longint          sa, sb, sres;
    longint unsigned cu;
    logic            c, v, arith;
    ua = 64'(rn); ub = 64'(s2);
    sa = longint'($signed(rn)); sb = longint'($signed(s2));
    cu = 64'(f[1]);
    arith = 1'b1; c = f[1]; full = 0; sres = 0; r = 0;
    case (cmd)
      4'h4, 4'hB: begin full = ua + ub;      c = full[32];           sres = sa + sb; end
      4'h5:       begin full = ua + ub + cu; c = full[32];           sres = sa + sb + longint'(cu); end
      4'h2, 4'hA: begin full = ua - ub;      c = (ua >= ub);         sres = sa - sb; end
      4'h3:       begin full = ub - ua;      c = (ub >= ua);         sres = sb - sa; end
      4'h6:       begin full = ua - ub - (1 - cu); c = (ua >= ub + (1 - cu));
                        sres = sa - sb - longint'(1 - cu); end
      4'h7:       begin full = ub - ua - (1 - cu); c = (ub >= ua + (1 - cu));
                        sres = sb - sa - longint'(1 - cu); end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      r = full[31:0];
      v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    end else begin
      case (cmd)
        4'h0, 4'h8: r = rn & s2;
        4'h1, 4'h9: r = rn ^ s2;
        4'hC:       r = rn | s2;
        4'hD:       r = s2;
        4'hE:       r = rn & ~s2;
        default:    r = ~s2;
      endcase
      c = ws ? cb : f[1];
      v = f[0];
    end
    nf = {r[31], r == 32'd0, c, v};
  endtask

  // Drive one cycle, update the model and push its expectation, then pop and
  // compare after the edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] cond,
                      input logic [3:0] cmd, input logic s, input logic [3:0] rd,
                      input logic [31:0] rn, input logic [31:0] s2, input logic ws,
                      input logic cb, input logic fl, input logic [3:0] fin);
    logic [31:0] r;
    logic [3:0]  nf;
    logic        pass, cmpop;
    exp_t        e;
    RESET_N = rst; in_valid = v; IR_cond = cond; IR_cmd = cmd; IR_S = s; IR_Rd = rd;
    RF_Rn = rn; src2 = s2; was_shifted = ws; carryBit = cb; flags_ld = fl; flags_in = fin;
    if (!rst) begin
      m = '0;
    end else begin
      alu_model(cmd, rn, s2, ws, cb, m.fl, r, nf);
      pass  = cond_model(cond, m.fl);
      cmpop = (cmd >= 4'h8) && (cmd <= 4'hB);
      if (v) begin
        m.res = r; m.rd = rd; m.cp = pass; m.wb = pass & ~cmpop; m.rv = 1'b1;
        if (pass && (s || cmpop)) m.fl = nf;
      end else begin
        m.wb = 1'b0; m.rv = 1'b0;
      end
      if (fl) m.fl = fin;
    end
    exp_q.push_back(m);
    @(posedge CLOCK_50);
    #1;
    e = exp_q.pop_front();
    check_eq("result", result, e.res);
    check_eq("wb_Rd", 32'(wb_Rd), 32'(e.rd));
    check_eq("wb_en", 32'(wb_en), 32'(e.wb));
    check_eq("result_valid", 32'(result_valid), 32'(e.rv));
    check_eq("cond_pass", 32'(cond_pass), 32'(e.cp));
    check_eq("flags", 32'(flags), 32'(e.fl));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m = '0;
    // Reset, with an instruction and a flag load offered at the same time.
    step(0, 1, 4'hE, 4'h4, 1, 4'd3, 32'd1, 32'd2, 0, 0, 1, 4'hF);
    step(0, 0, 4'hE, 4'h0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 4'h0);
    check_eq("tp_reset_flags", 32'(flags), 32'h0);

    // ADDS overflow into the sign bit.
    step(1, 1, 4'hE, 4'h4, 1, 4'd1, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 4'h0);
    check_eq("tp_adds_res", result, 32'h8000_0000);
    check_eq("tp_adds_flags", 32'(flags), 32'h9);
    check_eq("tp_adds_wb", 32'(wb_en), 32'd1);
    // CMP 5,5 then MOVEQ.
    step(1, 1, 4'hE, 4'hA, 0, 4'd2, 32'd5, 32'd5, 0, 0, 0, 4'h0);
    check_eq("tp_cmp_flags", 32'(flags), 32'h6);
    check_eq("tp_cmp_wb", 32'(wb_en), 32'd0);
    step(1, 1, 4'h0, 4'hD, 0, 4'd4, 32'd0, 32'hAB, 0, 0, 0, 4'h0);
    check_eq("tp_moveq_res", result, 32'hAB);
    check_eq("tp_moveq_pass", 32'(cond_pass), 32'd1);
    // ADC with C=1, no S.
    step(1, 1, 4'hE, 4'h5, 0, 4'd5, 32'd1, 32'd1, 0, 0, 0, 4'h0);
    check_eq("tp_adc_res", result, 32'd3);
    check_eq("tp_adc_flags", 32'(flags), 32'h6);
    // SBCS with C=0.
    step(1, 0, 4'hE, 4'h0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 1, 4'h0);
    step(1, 1, 4'hE, 4'h6, 1, 4'd6, 32'd0, 32'd0, 0, 0, 0, 4'h0);
    check_eq("tp_sbcs_res", result, 32'hFFFF_FFFF);
    check_eq("tp_sbcs_flags", 32'(flags), 32'h8);
    // MOVS with shifter carry, then without.
    step(1, 0, 4'hE, 4'h0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 1, 4'h1);
    step(1, 1, 4'hE, 4'hD, 1, 4'd7, 32'd9, 32'd0, 1, 1, 0, 4'h0);
    check_eq("tp_movs_ws_flags", 32'(flags), 32'h7);
    step(1, 0, 4'hE, 4'h0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 1, 4'h1);
    step(1, 1, 4'hE, 4'hD, 1, 4'd7, 32'd9, 32'd0, 0, 1, 0, 4'h0);
    check_eq("tp_movs_nows_flags", 32'(flags), 32'h5);
    // ADDSNE while Z=1, then NV.
    step(1, 1, 4'h1, 4'h4, 1, 4'd8, 32'd1, 32'd1, 0, 0, 0, 4'h0);
    check_eq("tp_ne_pass", 32'(cond_pass), 32'd0);
    check_eq("tp_ne_wb", 32'(wb_en), 32'd0);
    check_eq("tp_ne_rv", 32'(result_valid), 32'd1);
    check_eq("tp_ne_flags", 32'(flags), 32'h5);
    step(1, 1, 4'hF, 4'h4, 1, 4'd9, 32'd1, 32'd1, 0, 0, 0, 4'h0);
    check_eq("tp_nv_pass", 32'(cond_pass), 32'd0);
    // Flag load beats CMP in the same cycle.
    step(1, 1, 4'hE, 4'hA, 0, 4'd1, 32'd1, 32'd2, 0, 0, 1, 4'hA);
    check_eq("tp_ld_flags", 32'(flags), 32'hA);
    // Reset with an instruction in flight.
    step(0, 1, 4'hE, 4'h4, 1, 4'd5, 32'd1, 32'd1, 0, 0, 0, 4'h0);
    check_eq("tp_rst_res", result, 32'd0);
    check_eq("tp_rst_rv", 32'(result_valid), 32'd0);

    // Random back-to-back traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom),
           4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 1'($urandom),
           1'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dp_alu_flags.md
# dp_alu_flags

Execute-stage ALU for data-processing instructions. Consumes the registered second operand (`src2`, `was_shifted`, `carryBit`) produced by the operand shifter together with `RF_Rn` and instruction fields, evaluates the condition field against the current NZCV register, computes the result, updates NZCV and issues a registered write-back request for Rd. It sits directly downstream of the shifter, one pipeline register later.

## Interface
Parameters: none (datapath fixed at 32 bits).

- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `RESET_N`  in  1  synchronous, active-low reset
- `in_valid`  in  1  operands and fields valid this cycle
- `IR_cond`  in  4  condition field (ARM encoding)
- `IR_cmd`  in  4  data-processing opcode (ARM encoding)
- `IR_S`  in  1  set-flags bit
- `IR_Rd`  in  4  destination register index
- `RF_Rn`  in  32  first operand
- `src2`  in  32  second operand from shifter
- `was_shifted`  in  1  shifter applied a nonzero shift or rotate
- `carryBit`  in  1  shifter carry-out, meaningful only when `was_shifted`=1
- `flags_ld`  in  1  load NZCV from `flags_in` (MSR path)
- `flags_in`  in  4  {N,Z,C,V} to load
- `result`  out  32  ALU result
- `wb_Rd`  out  4  registered copy of `IR_Rd`
- `wb_en`  out  1  write `result` to `wb_Rd` this cycle
- `result_valid`  out  1  one-cycle pulse, an instruction retired this cycle
- `cond_pass`  out  1  condition outcome of the retired instruction
- `flags`  out  4  current {N,Z,C,V}

## Operation
- Condition is checked against `flags` as held before this instruction: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 (NV) 0.
- Ops: AND, EOR, SUB (Rn-src2), RSB (src2-Rn), ADD, ADC (+C), SBC (Rn-src2-!C), RSC (src2-Rn-!C), TST (AND), TEQ (EOR), CMP (SUB), CMN (ADD), ORR, MOV (src2), BIC (Rn&~src2), MVN (~src2).
- Arithmetic is done in 33 bits; C = bit 32 for add forms, C = NOT borrow for subtract forms (so 5-5 gives C=1). V = signed overflow of the 32-bit result.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = `carryBit` if `was_shifted`, else C unchanged; V always unchanged.
- Flag update happens when the condition passes and (`IR_S`=1 or op is TST/TEQ/CMP/CMN). Compare ops ignore `IR_S` and never write back.
- `wb_en` = condition passed and op not in {TST,TEQ,CMP,CMN}. A failed condition leaves `result` holding the computed value, with `wb_en`=0 and flags unchanged.
- `flags_ld` and an instruction flag update in the same cycle: `flags_ld` wins.

## Timing
- Single-cycle registered stage. Inputs are sampled at edge k when `in_valid`=1. `result`, `wb_Rd`, `wb_en`, `result_valid`, `cond_pass` and `flags` update at edge k and are visible during cycle k+1.
- Back-to-back instructions are supported every cycle. An instruction sampled at edge k+1 evaluates its condition against flags written at edge k, so no bypass hazard exists.
- With `in_valid`=0: `result_valid`=0 and `wb_en`=0 next cycle; `result`, `wb_Rd`, `cond_pass` and `flags` hold.
- Reset (`RESET_N`=0 at an edge): `result`=0, `wb_Rd`=0, `wb_en`=0, `result_valid`=0, `cond_pass`=0, `flags`=4'b0000. Reset overrides `in_valid` and `flags_ld` in the same cycle. An instruction in flight is dropped, with no write-back.

## Test plan
- ADDS, Rn=0x7FFFFFFF, src2=1, cond AL -> result 0x80000000, wb_en=1, flags N=1 Z=0 C=0 V=1.
- CMP Rn=5, src2=5, then next cycle MOV cond EQ src2=0xAB -> first: wb_en=0, flags Z=1 C=1. Second: cond_pass=1, result 0xAB, wb_en=1.
- ADC with C=1, Rn=1, src2=1, S=0 -> result 3, flags unchanged. SBCS with C=0, Rn=0, src2=0 -> 0xFFFFFFFF, N=1 C=0.
- MOVS src2=0, was_shifted=1, carryBit=1, with V=1 beforehand -> Z=1, C=1, V stays 1. Repeat with was_shifted=0 and prior C=0 -> C stays 0.
- ADDS with cond NE while Z=1 -> cond_pass=0, wb_en=0, result_valid=1, flags unchanged. Cond 1111 -> always fails.
- `flags_ld`=1, flags_in=4'b1010, same cycle as CMP 1,2 -> flags=1010. Then `RESET_N`=0 with `in_valid`=1 -> all outputs 0 next cycle.
